// File: rtl/stack_alu_pkg.sv
// Shared opcodes, state encodings and sizing helpers for the stack calculator.
package stack_alu_pkg;

  localparam logic [3:0] OP_POP  = 4'd0;
  localparam logic [3:0] OP_DUP  = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd3;
  localparam logic [3:0] OP_MUL  = 4'd4;
  localparam logic [3:0] OP_DIV  = 4'd5;
  localparam logic [3:0] OP_MOD  = 4'd6;
  localparam logic [3:0] OP_PUSH = 4'd7;
  localparam logic [3:0] OP_SWAP = 4'd8;

  typedef enum logic {CTL_IDLE, CTL_DIVIDE} ctl_state_t;
  typedef enum logic {DIV_IDLE, DIV_RUN} div_state_t;

  // Iterations needed by the restoring divider: one per quotient bit.
  function automatic int unsigned div_iter(input int unsigned w);
    return w;
  endfunction

  // Width of an occupancy counter able to hold 0..depth.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/stack_alu_divider.sv
// Restoring unsigned divider, one quotient bit per clock.
// done is asserted during the final iteration cycle with the finished
// quotient/remainder presented combinationally, so the caller can write the
// result back on the same edge that retires the last iteration.
module seq_divider
  import stack_alu_pkg::*;
#(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         done,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder
);

  localparam int unsigned CNTW = $clog2(W + 1);

  div_state_t      state;
  logic [CNTW-1:0] iter_left;
  logic [W-1:0]    rem;
  logic [W-1:0]    quo;
  logic [W-1:0]    dsr;
  logic [W:0]      shifted;
  logic [W:0]      diff;
  logic [W-1:0]    rem_next;
  logic [W-1:0]    quo_next;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    shifted = {rem, quo[W-1]};
    diff    = shifted - {1'b0, dsr};
    if (!diff[W]) begin
      rem_next = diff[W-1:0];
      quo_next = {quo[W-2:0], 1'b1};
    end else begin
      rem_next = shifted[W-1:0];
      quo_next = {quo[W-2:0], 1'b0};
    end
  end

  assign done      = (state == DIV_RUN) && (iter_left == CNTW'(1));
  assign quotient  = quo_next;
  assign remainder = rem_next;

  // Operand latch on start, then W iteration steps.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= DIV_IDLE;
      iter_left <= '0;
      rem       <= '0;
      quo       <= '0;
      dsr       <= '0;
    end else begin
      case (state)
        DIV_IDLE: begin
          if (start) begin
            rem       <= '0;
            quo       <= dividend;
            dsr       <= divisor;
            iter_left <= CNTW'(div_iter(W));
            state     <= DIV_RUN;
          end
        end
        DIV_RUN: begin
          rem       <= rem_next;
          quo       <= quo_next;
          iter_left <= iter_left - CNTW'(1);
          if (iter_left == CNTW'(1)) state <= DIV_IDLE;
        end
        default: state <= DIV_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/stack_alu.sv
// RPN stack calculator: register-file stack, single-cycle ALU and an
// iterative divider for DIV/MOD with a busy handshake.
module stack_alu
  import stack_alu_pkg::*;
#(
  parameter int unsigned W     = 16,
  parameter int unsigned DEPTH = 12
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [W-1:0]                 in,
  input  logic [3:0]                   op,
  input  logic                         apply,
  output logic [W-1:0]                 head,
  output logic                         empty,
  output logic                         full,
  output logic [cnt_width(DEPTH)-1:0]  count,
  output logic                         valid,
  output logic                         busy
);

  localparam int unsigned CW = cnt_width(DEPTH);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  ctl_state_t    state;
  logic          is_mod;

  logic [CW-1:0] tos_ptr;
  logic [CW-1:0] nos_ptr;
  logic [AW-1:0] tos_idx;
  logic [AW-1:0] nos_idx;
  logic [AW-1:0] push_idx;
  logic [W-1:0]  tos;
  logic [W-1:0]  nos;
  logic [W-1:0]  alu_res;
  logic          has1;
  logic          has2;

  logic          accept;
  logic          start_div;
  logic [CW-1:0] next_count;
  logic          wr0_en;
  logic          wr1_en;
  logic [AW-1:0] wr0_idx;
  logic [AW-1:0] wr1_idx;
  logic [W-1:0]  wr0_data;
  logic [W-1:0]  wr1_data;

  logic          div_done;
  logic [W-1:0]  div_q;
  logic [W-1:0]  div_r;

  assign tos_ptr  = count - CW'(1);
  assign nos_ptr  = count - CW'(2);
  assign tos_idx  = tos_ptr[AW-1:0];
  assign nos_idx  = nos_ptr[AW-1:0];
  assign push_idx = count[AW-1:0];
  assign tos      = mem[tos_idx];
  assign nos      = mem[nos_idx];

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  assign has1  = !empty;
  assign has2  = (count >= CW'(2));
  assign busy  = (state == CTL_DIVIDE);
  assign head  = empty ? '0 : tos;

  // Single-cycle arithmetic on NOS (left) and TOS (right), modulo 2^W.
  always_comb begin
    alu_res = '0;
    case (op)
      OP_ADD:  alu_res = nos + tos;
      OP_SUB:  alu_res = nos - tos;
      OP_MUL:  alu_res = nos * tos;
      default: alu_res = '0;
    endcase
  end

  // Opcode legality, stack write ports and divider write-back.
  always_comb begin
    accept     = 1'b0;
    start_div  = 1'b0;
    next_count = count;
    wr0_en     = 1'b0;
    wr0_idx    = push_idx;
    wr0_data   = in;
    wr1_en     = 1'b0;
    wr1_idx    = tos_idx;
    wr1_data   = nos;
    if (state == CTL_DIVIDE) begin
      if (div_done) begin
        wr0_en   = 1'b1;
        wr0_idx  = nos_idx;
        wr0_data = is_mod ? div_r : div_q;
      end
    end else if (apply) begin
      case (op)
        OP_POP: begin
          if (has1) begin
            accept     = 1'b1;
            next_count = count - CW'(1);
          end
        end
        OP_DUP: begin
          if (has1 && !full) begin
            accept     = 1'b1;
            wr0_en     = 1'b1;
            wr0_data   = tos;
            next_count = count + CW'(1);
          end
        end
        OP_ADD, OP_SUB, OP_MUL: begin
          if (has2) begin
            accept     = 1'b1;
            wr0_en     = 1'b1;
            wr0_idx    = nos_idx;
            wr0_data   = alu_res;
            next_count = count - CW'(1);
          end
        end
        OP_DIV, OP_MOD: begin
          if (has2 && (tos != '0)) start_div = 1'b1;
        end
        OP_PUSH: begin
          if (!full) begin
            accept     = 1'b1;
            wr0_en     = 1'b1;
            next_count = count + CW'(1);
          end
        end
        OP_SWAP: begin
          if (has2) begin
            accept   = 1'b1;
            wr0_en   = 1'b1;
            wr0_idx  = nos_idx;
            wr0_data = tos;
            wr1_en   = 1'b1;
          end
        end
        default: accept = 1'b0;
      endcase
    end
  end

  seq_divider #(.W(W)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (start_div),
    .dividend  (nos),
    .divisor   (tos),
    .done      (div_done),
    .quotient  (div_q),
    .remainder (div_r)
  );

  // Command sequencing: occupancy, status and the divide wait state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= CTL_IDLE;
      count  <= '0;
      valid  <= 1'b0;
      is_mod <= 1'b0;
    end else begin
      case (state)
        CTL_IDLE: begin
          if (apply) begin
            if (start_div) begin
              state  <= CTL_DIVIDE;
              is_mod <= (op == OP_MOD);
            end else begin
              valid <= accept;
              count <= next_count;
            end
          end
        end
        CTL_DIVIDE: begin
          if (div_done) begin
            count <= count - CW'(1);
            valid <= 1'b1;
            state <= CTL_IDLE;
          end
        end
        default: state <= CTL_IDLE;
      endcase
    end
  end

  // Stack storage; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (wr0_en) mem[wr0_idx] <= wr0_data;
    if (wr1_en) mem[wr1_idx] <= wr1_data;
  end

endmodule

// File: tb/tb_stack_alu.sv
// Self-checking bench for stack_alu: a reference stack model pushes expected
// status snapshots to a scoreboard; each scenario pops and compares them.
module tb_stack_alu;

  localparam int W     = 16;
  localparam int DEPTH = 12;

  localparam logic [3:0] P_POP  = 4'd0;
  localparam logic [3:0] P_DUP  = 4'd1;
  localparam logic [3:0] P_ADD  = 4'd2;
  localparam logic [3:0] P_SUB  = 4'd3;
  localparam logic [3:0] P_MUL  = 4'd4;
  localparam logic [3:0] P_DIV  = 4'd5;
  localparam logic [3:0] P_MOD  = 4'd6;
  localparam logic [3:0] P_PUSH = 4'd7;
  localparam logic [3:0] P_SWAP = 4'd8;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        apply = 1'b0;
  logic [15:0] in_d  = '0;
  logic [3:0]  op    = '0;
  logic [15:0] head;
  logic        empty;
  logic        full;
  logic        valid;
  logic        busy;
  logic [3:0]  count;
  logic [23:0] obs;

  int          checks = 0;
  int          errors = 0;
  int unsigned stk[$];
  logic        mvalid = 1'b0;
  logic [23:0] sb[$];
  logic [23:0] exp_v;
  int          bcyc;

  assign obs = {head, count, valid, empty, full, busy};

  always #5 clk = ~clk;

  stack_alu #(.W(W), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst   (rst_n),
    .in    (in_d),
    .op    (op),
    .apply (apply),
    .head  (head),
    .empty (empty),
    .full  (full),
    .count (count),
    .valid (valid),
    .busy  (busy)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [23:0] snapshot();
    logic [15:0] h;
    logic [3:0]  c;
    c = 4'(stk.size());
    h = (stk.size() == 0) ? 16'h0 : 16'(stk[stk.size()-1]);
    return {h, c, mvalid, (stk.size() == 0), (stk.size() == DEPTH), 1'b0};
  endfunction

  function automatic void model_op(input logic [3:0] o, input logic [15:0] d);
    int unsigned n;
    int unsigned a;
    int unsigned b;
    n = stk.size();
    mvalid = 1'b0;
    case (o)
      0: if (n >= 1) begin void'(stk.pop_back()); mvalid = 1'b1; end
      1: if (n >= 1 && n < DEPTH) begin stk.push_back(stk[n-1]); mvalid = 1'b1; end
      2, 3, 4: if (n >= 2) begin
        b = stk.pop_back();
        a = stk.pop_back();
        if (o == 2) stk.push_back((a + b) & 32'hFFFF);
        else if (o == 3) stk.push_back((a - b) & 32'hFFFF);
        else stk.push_back((a * b) & 32'hFFFF);
        mvalid = 1'b1;
      end
      5, 6: if (n >= 2 && stk[n-1] != 0) begin
        b = stk.pop_back();
        a = stk.pop_back();
        stk.push_back((o == 5) ? a / b : a % b);
        mvalid = 1'b1;
      end
      7: if (n < DEPTH) begin stk.push_back(32'(d)); mvalid = 1'b1; end
      8: if (n >= 2) begin
        a = stk[n-1];
        stk[n-1] = stk[n-2];
        stk[n-2] = a;
        mvalid = 1'b1;
      end
      default: mvalid = 1'b0;
    endcase
    sb.push_back(snapshot());
  endfunction

  // Entered and left at a falling edge.
  task automatic do_reset();
    apply = 1'b0;
    rst_n = 1'b0;
    stk.delete();
    mvalid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Drive one command, wait for completion; optionally re-apply while busy.
  task automatic issue(input logic [3:0] o, input logic [15:0] d, input bit poke, output int bc);
    apply = 1'b1;
    op    = o;
    in_d  = d;
    model_op(o, d);
    @(posedge clk);
    @(negedge clk);
    apply = 1'b0;
    bc = 0;
    while (busy && bc < 100) begin
      bc++;
      if (poke && bc == 3) begin
        apply = 1'b1;
        op    = P_PUSH;
        in_d  = 16'h1234;
      end else begin
        apply = 1'b0;
      end
      @(negedge clk);
    end
    apply = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    stk.delete();
    mvalid = 1'b0;
    sb.push_back(snapshot());
    exp_v = sb.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL reset: got %h expected %h", obs, exp_v); end
    do_reset();
  endtask

  task automatic test_illegal();
    for (int o = 9; o < 16; o++) begin
      do_reset();
      issue(4'(o), 16'h00AA, 1'b0, bcyc);
      exp_v = sb.pop_front(); checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL illegal_op %0d: got %h expected %h", o, obs, exp_v); end
    end
  endtask

  task automatic test_short_stack();
    logic [3:0] e_ops [3];
    e_ops = '{P_POP, P_DUP, P_SWAP};
    do_reset();
    issue(P_PUSH, 16'd1, 1'b0, bcyc);
    exp_v = sb.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL push_one: got %h expected %h", obs, exp_v); end
    for (int o = 2; o <= 6; o++) begin
      issue(4'(o), 16'h0, 1'b0, bcyc);
      exp_v = sb.pop_front(); checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL short_binop %0d: got %h expected %h", o, obs, exp_v); end
    end
    do_reset();
    for (int i = 0; i < 3; i++) begin
      issue(e_ops[i], 16'h0, 1'b0, bcyc);
      exp_v = sb.pop_front(); checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL empty_op %0d: got %h expected %h", e_ops[i], obs, exp_v); end
    end
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 0; i < DEPTH + 1; i++) begin
      issue(P_PUSH, 16'd1, 1'b0, bcyc);
      exp_v = sb.pop_front(); checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL fill push %0d: got %h expected %h", i + 1, obs, exp_v); end
    end
  endtask

  task automatic test_div_by_zero();
    logic [3:0] d_ops [2];
    d_ops = '{P_DIV, P_MOD};
    do_reset();
    issue(P_PUSH, 16'd5, 1'b0, bcyc);
    void'(sb.pop_front());
    issue(P_PUSH, 16'd0, 1'b0, bcyc);
    void'(sb.pop_front());
    for (int i = 0; i < 2; i++) begin
      issue(d_ops[i], 16'h0, 1'b0, bcyc);
      exp_v = sb.pop_front(); checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL div_by_zero op %0d: got %h expected %h", d_ops[i], obs, exp_v); end
      checks++;
      if (bcyc != 0) begin errors++; $display("FAIL div_by_zero_busy: got %0d busy cycles expected 0", bcyc); end
    end
  endtask

  task automatic test_arith();
    logic [3:0]  a_ops [19];
    logic [15:0] a_dat [19];
    a_ops = '{P_PUSH, P_PUSH, P_SUB, P_PUSH, P_SUB, P_PUSH, P_SUB, P_PUSH, P_SUB,
              P_PUSH, P_PUSH, P_MUL, P_ADD, P_SWAP, P_DUP, P_POP, P_PUSH, P_ADD, P_SWAP};
    a_dat = '{16'd7, 16'd3, 16'd0, 16'd3, 16'd0, 16'd0, 16'd0, 16'd2, 16'd0,
              16'h0100, 16'h0100, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd2, 16'd0, 16'd0};
    do_reset();
    for (int i = 0; i < 19; i++) begin
      issue(a_ops[i], a_dat[i], 1'b0, bcyc);
      exp_v = sb.pop_front(); checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL arith step %0d op %0d: got %h expected %h", i, a_ops[i], obs, exp_v); end
    end
  endtask

  task automatic test_divide();
    logic [3:0] d_ops [2];
    d_ops = '{P_DIV, P_MOD};
    for (int i = 0; i < 2; i++) begin
      do_reset();
      issue(P_PUSH, 16'd100, 1'b0, bcyc);
      void'(sb.pop_front());
      issue(P_PUSH, 16'd7, 1'b0, bcyc);
      void'(sb.pop_front());
      issue(d_ops[i], 16'h0, 1'b1, bcyc);
      exp_v = sb.pop_front(); checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL divide op %0d: got %h expected %h", d_ops[i], obs, exp_v); end
      checks++;
      if (bcyc != W) begin errors++; $display("FAIL divide_busy_cycles op %0d: got %0d expected %0d", d_ops[i], bcyc, W); end
    end
    // Back-to-back: commands right after a divide completes.
    issue(P_PUSH, 16'd5, 1'b0, bcyc);
    exp_v = sb.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL back_to_back push: got %h expected %h", obs, exp_v); end
    issue(P_MUL, 16'd0, 1'b0, bcyc);
    exp_v = sb.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL back_to_back mul: got %h expected %h", obs, exp_v); end
    issue(P_PUSH, 16'd3, 1'b0, bcyc);
    void'(sb.pop_front());
    issue(P_DIV, 16'd0, 1'b0, bcyc);
    exp_v = sb.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL back_to_back div: got %h expected %h", obs, exp_v); end
  endtask

  task automatic test_reset_mid_div();
    do_reset();
    issue(P_PUSH, 16'd100, 1'b0, bcyc);
    void'(sb.pop_front());
    issue(P_PUSH, 16'd7, 1'b0, bcyc);
    exp_v = sb.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL pre_div: got %h expected %h", obs, exp_v); end
    apply = 1'b1;
    op    = P_DIV;
    @(posedge clk);
    @(negedge clk);
    apply = 1'b0;
    repeat (4) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    stk.delete();
    mvalid = 1'b0;
    sb.push_back(snapshot());
    exp_v = sb.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL reset_mid_div: got %h expected %h", obs, exp_v); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    sb.push_back(snapshot());
    exp_v = sb.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL post_abort: got %h expected %h", obs, exp_v); end
    issue(P_PUSH, 16'd9, 1'b0, bcyc);
    exp_v = sb.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL push_after_abort: got %h expected %h", obs, exp_v); end
  endtask

  initial begin
    test_reset();
    test_illegal();
    test_short_stack();
    test_fill();
    test_div_by_zero();
    test_arith();
    test_divide();
    test_reset_mid_div();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
